// File: rtl/memory_writer_pkg.sv
// Shared geometry and FSM encoding for the 3x3-window image pipeline back end.
`timescale 1ns/1ps
package memory_writer_pkg;

    // A 3x3 window trims one pixel from each border of the input image
    localparam int IMG_IN_W     = 100;
    localparam int IMG_IN_H     = 100;
    localparam int IMG_OUT_W    = IMG_IN_W - 2;
    localparam int IMG_OUT_H    = IMG_IN_H - 2;
    localparam int FRAME_PIXELS = IMG_OUT_W * IMG_OUT_H;
    localparam int MEM_ADDR_W   = 14;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } wr_state_t;

endpackage

// File: rtl/memory_writer_saturate.sv
// Combinational clamp of a signed filter result into an unsigned stored pixel.
`timescale 1ns/1ps
module pix_saturate #(
    parameter int IN_W  = 16,
    parameter int PIX_W = 8
) (
    input  logic signed [IN_W-1:0]  din,
    output logic        [PIX_W-1:0] dout
);

    // Negative clamps to zero; any set bit above the pixel field clamps to full scale
    always_comb begin
        dout = din[PIX_W-1:0];
        if (din[IN_W-1]) begin
            dout = '0;
        end else if (|din[IN_W-2:PIX_W]) begin
            dout = '1;
        end
    end

endmodule

// File: rtl/memory_writer.sv
// Writes one frame of saturated filter results into the output image RAM in raster order.
`timescale 1ns/1ps
module memory_writer
    import memory_writer_pkg::*;
#(
    parameter int OUT_W  = IMG_OUT_W,
    parameter int OUT_H  = IMG_OUT_H,
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int IN_W   = 16,
    parameter int PIX_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [IN_W-1:0]  pix_in,
    input  logic                    pix_valid,
    output logic                    pix_ready,
    output logic                    ram_we,
    output logic        [ADDR_W-1:0] ram_addr,
    output logic        [PIX_W-1:0]  ram_din,
    output logic                    busy,
    output logic                    frame_done,
    output logic        [ADDR_W-1:0] pix_count
);

    localparam int COL_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int ROW_W = (OUT_H > 1) ? $clog2(OUT_H + 1) : 1;

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(OUT_W - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(OUT_W);
    localparam logic [ADDR_W-1:0] LAST_BEAT = ADDR_W'(OUT_W * OUT_H - 1);

    wr_state_t state;
    wr_state_t state_next;

    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] beat_addr;
    logic [PIX_W-1:0]  pix_sat;
    logic              accept;
    logic              arm;

    assign pix_ready  = (state == ST_WRITE);
    assign busy       = (state == ST_WRITE);
    assign frame_done = (state == ST_DONE);
    assign accept     = pix_valid && pix_ready;
    assign arm        = (state == ST_IDLE) && start;

    // row_base steps by one row width on each wrap, so the address needs no multiplier
    assign beat_addr = row_base + ADDR_W'(col);

    pix_saturate #(
        .IN_W  (IN_W),
        .PIX_W (PIX_W)
    ) u_sat (
        .din  (pix_in),
        .dout (pix_sat)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (accept && (pix_count == LAST_BEAT)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_din   <= '0;
            pix_count <= '0;
            row       <= '0;
            col       <= '0;
            row_base  <= '0;
        end else begin
            ram_we <= accept;
            if (arm) begin
                pix_count <= '0;
                row       <= '0;
                col       <= '0;
                row_base  <= '0;
            end else if (accept) begin
                ram_addr  <= beat_addr;
                ram_din   <= pix_sat;
                pix_count <= pix_count + 1'b1;
                if (col == COL_LAST) begin
                    col      <= '0;
                    row      <= row + 1'b1;
                    row_base <= row_base + ROW_STEP;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_memory_writer.sv
// Scoreboard bench for memory_writer: expected RAM writes queued on accept, popped on ram_we.
`timescale 1ns/1ps
module tb_memory_writer;
    import memory_writer_pkg::*;

    localparam int FRAME = FRAME_PIXELS;

    logic              clk       = 1'b0;
    logic              rst       = 1'b1;
    logic              start     = 1'b0;
    logic              pix_valid = 1'b0;
    logic signed [15:0] pix_in   = '0;
    logic              pix_ready;
    logic              ram_we;
    logic [13:0]       ram_addr;
    logic [7:0]        ram_din;
    logic              busy;
    logic              frame_done;
    logic [13:0]       pix_count;

    typedef struct {
        int addr;
        int data;
        bit last;
    } exp_t;

    exp_t sb[$];
    int   checks      = 0;
    int   passes      = 0;
    int   done_pulses = 0;
    int   mstate      = 0;
    int   maddr       = 0;
    int   sat_vals[6] = '{-5, 0, 255, 256, 32767, -32768};

    memory_writer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .busy       (busy),
        .frame_done (frame_done),
        .pix_count  (pix_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int satModel(input int v);
        if (v < 0) return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    // Model: 0 idle, 1 write, 2 done. Called one time unit after a rising edge.
    task automatic applyStimulus(input int value, input bit valid, input bit st);
        exp_t e;
        pix_in    = 16'(value);
        pix_valid = valid;
        start     = st;
        checkOutput("pix_ready", {31'd0, pix_ready}, (mstate == 1) ? 32'd1 : 32'd0);
        case (mstate)
            0: begin
                if (st) begin
                    mstate = 1;
                    maddr  = 0;
                end
            end
            1: begin
                if (valid) begin
                    e.addr = maddr;
                    e.data = satModel(value);
                    e.last = (maddr == FRAME - 1);
                    sb.push_back(e);
                    if (maddr == FRAME - 1) mstate = 2;
                    maddr++;
                end
            end
            default: mstate = 0;
        endcase
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        start     = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            if (frame_done) done_pulses++;
            if (ram_we) begin
                if (sb.size() == 0) begin
                    checkOutput("spurious_we", {31'd0, ram_we}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("ram_addr", {18'd0, ram_addr}, e.addr);
                    checkOutput("ram_din", {24'd0, ram_din}, e.data);
                    checkOutput("frame_done_at_write", {31'd0, frame_done}, {31'd0, e.last});
                end
            end else begin
                checkOutput("frame_done_no_we", {31'd0, frame_done}, 32'd0);
            end
        end
    end

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ram_we"},    {31'd0, ram_we},     32'd0);
        checkOutput({tag, "_ram_addr"},  {18'd0, ram_addr},   32'd0);
        checkOutput({tag, "_ram_din"},   {24'd0, ram_din},    32'd0);
        checkOutput({tag, "_busy"},      {31'd0, busy},       32'd0);
        checkOutput({tag, "_done"},      {31'd0, frame_done}, 32'd0);
        checkOutput({tag, "_pix_count"}, {18'd0, pix_count},  32'd0);
        checkOutput({tag, "_pix_ready"}, {31'd0, pix_ready},  32'd0);
    endtask

    task automatic finishFrame(input int exp_pulses);
        applyStimulus(0, 0, 0);
        applyStimulus(7, 1, 0);
        checkOutput("pix_count_end", {18'd0, pix_count}, FRAME);
        checkOutput("done_pulses", done_pulses, exp_pulses);
        checkOutput("sb_empty", sb.size(), 0);
        checkOutput("busy_end", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #2 rst = 1'b0;
        #1 checkAllZero("por");
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;

        $display("[TB] idle: valid without start must not be accepted");
        for (int i = 0; i < 3; i++) applyStimulus(123, 1, 0);
        checkOutput("idle_busy", {31'd0, busy}, 32'd0);

        $display("[TB] frame 1: full frame, pix = k mod 200");
        applyStimulus(0, 0, 1);
        checkOutput("busy_write", {31'd0, busy}, 32'd1);
        for (int k = 0; k < FRAME; k++) applyStimulus(k % 200, 1, 0);
        finishFrame(1);

        $display("[TB] frame 2: saturation, gaps at row wrap, stray start");
        applyStimulus(0, 0, 1);
        for (int k = 0; k < FRAME; k++) begin
            if (k == 98) begin
                applyStimulus(0, 0, 0);
                applyStimulus(0, 0, 0);
            end
            applyStimulus((k < 6) ? sat_vals[k] : (k % 200), 1, k == 500);
        end
        finishFrame(2);

        $display("[TB] frame 3: asynchronous reset mid-frame");
        applyStimulus(0, 0, 1);
        for (int k = 0; k < 3000; k++) applyStimulus(k % 200, 1, 0);
        checkOutput("pre_reset_count", {18'd0, pix_count}, 3000);
        #1 rst = 1'b0;
        #1 checkAllZero("mid_reset");
        sb.delete();
        mstate = 0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        checkOutput("post_reset_ready", {31'd0, pix_ready}, 32'd0);
        checkOutput("post_reset_busy", {31'd0, busy}, 32'd0);

        $display("[TB] frame 4: fresh frame after reset");
        applyStimulus(0, 0, 1);
        for (int k = 0; k < FRAME; k++) applyStimulus((k * 3) % 200, 1, 0);
        finishFrame(3);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
